// File: rtl/ring_ctrl.sv
// Per-cluster ring-router sequencer: latches one slide/reduction op, configures the router, gates SLDU handshakes, counts beats.
// Latency: accept -> CFG (1 cycle) -> BUSY -> done_o one cycle after the last counted beat; beats==0 gives done_o at accept+2.
// Backpressure: req_ready_o only in IDLE; beats are counted only on observed valid&ready while the matching enable is high.
// Optional watchdog: define RING_CTRL_TIMEOUT_EN to end a stalled BUSY phase after TimeoutCycles beat-less cycles.
module ring_ctrl #(
    parameter int BeatCntWidth  = 16,
    parameter int TimeoutCycles = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_dir_i,
    input  logic                    req_bypass_i,
    input  logic [BeatCntWidth-1:0] req_beats_i,
    output logic                    ring_dir_o,
    output logic                    ring_bypass_o,
    input  logic                    tx_valid_i,
    input  logic                    tx_ready_i,
    output logic                    tx_en_o,
    input  logic                    rx_valid_i,
    input  logic                    rx_ready_i,
    output logic                    rx_en_o,
    input  logic                    fwd_valid_i,
    input  logic                    fwd_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [BeatCntWidth-1:0] tx_cnt_o,
    output logic [BeatCntWidth-1:0] rx_cnt_o,
    output logic                    timeout_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CFG  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    if (BeatCntWidth < 1 || TimeoutCycles < 1) begin : g_bad_params
        $error("ring_ctrl: BeatCntWidth and TimeoutCycles must be at least 1");
    end

    logic [1:0]              state_q, state_d;
    logic                    dir_q, dir_d;
    logic                    bypass_q, bypass_d;
    logic [BeatCntWidth-1:0] beats_q, beats_d;
    logic [BeatCntWidth-1:0] tx_cnt_q, tx_cnt_d;
    logic [BeatCntWidth-1:0] rx_cnt_q, rx_cnt_d;
    logic                    tx_more, rx_more;
    logic                    in_busy;
    logic                    tx_beat, rx_beat;
    logic                    xfer_done;
    logic                    wd_expire;

    // Counters saturate at the latched beat count, so "more to do" is a plain compare.
    assign tx_more = (tx_cnt_q < beats_q);
    assign rx_more = (rx_cnt_q < beats_q);
    assign in_busy = (state_q == ST_BUSY);

    assign tx_en_o = in_busy & ~bypass_q & tx_more;
    assign rx_en_o = in_busy & ~bypass_q & rx_more;

    // In bypass the forwarded stream is what completes the op; local TX never counts.
    assign tx_beat = tx_valid_i & tx_ready_i & tx_en_o;
    assign rx_beat = bypass_q ? (in_busy & fwd_valid_i & fwd_ready_i & rx_more)
                              : (rx_valid_i & rx_ready_i & rx_en_o);

    // Reset state is IDLE, but nothing is accepted until reset is released.
    assign req_ready_o   = (state_q == ST_IDLE) & ~rst_i;
    assign busy_o        = (state_q == ST_CFG) | in_busy;
    assign done_o        = (state_q == ST_DONE);
    assign ring_dir_o    = dir_q;
    assign ring_bypass_o = bypass_q;
    assign tx_cnt_o      = tx_cnt_q;
    assign rx_cnt_o      = rx_cnt_q;

`ifdef RING_CTRL_TIMEOUT_EN
    localparam int WdWidth = $clog2(TimeoutCycles) + 1;

    logic [WdWidth-1:0] wdog_q, wdog_d;
    logic               timeout_q;

    // Watchdog: cleared on accept and on any counted beat, advances on each beat-less BUSY cycle.
    always_comb begin
        wdog_d    = wdog_q;
        wd_expire = 1'b0;
        if (state_q == ST_IDLE && req_valid_i) begin
            wdog_d = '0;
        end else if (in_busy) begin
            if (tx_beat | rx_beat) begin
                wdog_d = '0;
            end else begin
                wdog_d    = wdog_q + WdWidth'(1);
                wd_expire = (wdog_d == WdWidth'(TimeoutCycles));
            end
        end
    end

    // Watchdog state; the flag is set only when BUSY leaves through expiry, so it lives for the DONE cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= in_busy & wd_expire;
        end
    end

    assign timeout_o = done_o & timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Next-state: latch the op in IDLE, one settle cycle in CFG, count in BUSY, one-cycle DONE pulse.
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        bypass_d  = bypass_q;
        beats_d   = beats_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        xfer_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    dir_d    = req_dir_i;
                    bypass_d = req_bypass_i;
                    beats_d  = req_beats_i;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    state_d  = ST_CFG;
                end
            end
            ST_CFG: begin
                state_d = (beats_q == '0) ? ST_DONE : ST_BUSY;
            end
            ST_BUSY: begin
                if (tx_beat) tx_cnt_d = tx_cnt_q + BeatCntWidth'(1);
                if (rx_beat) rx_cnt_d = rx_cnt_q + BeatCntWidth'(1);
                // Completion is judged on the post-increment counts so done_o follows the last beat by one cycle.
                xfer_done = bypass_q ? (rx_cnt_d == beats_q)
                                     : ((tx_cnt_d == beats_q) && (rx_cnt_d == beats_q));
                if (xfer_done || wd_expire) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and op registers; reset aborts any op without a done pulse and parks the router in bypass.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            bypass_q <= 1'b1;
            beats_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            bypass_q <= bypass_d;
            beats_q  <= beats_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

endmodule

// File: tb/tb_ring_ctrl.sv
// Self-checking bench for ring_ctrl: directed ops plus randomized handshake traffic against a beat-count model.
// Latency: checks every cycle on the falling edge; inputs change on the falling edge after checks.
// Backpressure: random valid/ready densities per op; stall windows exercise the optional watchdog.
module tb_ring_ctrl;

    localparam int W  = 16;
    localparam int TO = 8;
`ifdef RING_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic         req_dir_i = 1'b0;
    logic         req_bypass_i = 1'b0;
    logic [W-1:0] req_beats_i = '0;
    logic         ring_dir_o, ring_bypass_o;
    logic         tx_valid_i = 1'b0, tx_ready_i = 1'b0, tx_en_o;
    logic         rx_valid_i = 1'b0, rx_ready_i = 1'b0, rx_en_o;
    logic         fwd_valid_i = 1'b0, fwd_ready_i = 1'b0;
    logic         busy_o, done_o, timeout_o;
    logic [W-1:0] tx_cnt_o, rx_cnt_o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_i = ~clk_i;

    ring_ctrl #(.BeatCntWidth(W), .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dir_i(req_dir_i), .req_bypass_i(req_bypass_i), .req_beats_i(req_beats_i),
        .ring_dir_o(ring_dir_o), .ring_bypass_o(ring_bypass_o),
        .tx_valid_i(tx_valid_i), .tx_ready_i(tx_ready_i), .tx_en_o(tx_en_o),
        .rx_valid_i(rx_valid_i), .rx_ready_i(rx_ready_i), .rx_en_o(rx_en_o),
        .fwd_valid_i(fwd_valid_i), .fwd_ready_i(fwd_ready_i),
        .busy_o(busy_o), .done_o(done_o),
        .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o), .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random handshake levels with percentage density; quiet forces everything low.
    task automatic drive_hs(input int p_tx, input int p_rx, input bit quiet);
        tx_valid_i  = !quiet && (int'($urandom_range(99)) < p_tx);
        tx_ready_i  = !quiet && (int'($urandom_range(99)) < p_tx);
        rx_valid_i  = !quiet && (int'($urandom_range(99)) < p_rx);
        rx_ready_i  = !quiet && (int'($urandom_range(99)) < p_rx);
        fwd_valid_i = !quiet && (int'($urandom_range(99)) < p_rx);
        fwd_ready_i = !quiet && (int'($urandom_range(99)) < p_rx);
    endtask

    // One complete op, entered and left on a falling edge in IDLE.
    task automatic run_op(input bit dir, input bit byp, input int beats,
                          input int p_tx, input int p_rx, input int stall,
                          input bit nx_hold, input bit nx_dir, input bit nx_byp, input int nx_beats);
        int mtx, mrx, wd, k;
        bit fin, to_hit, tx_b, rx_b;
        req_valid_i  = 1'b1;
        req_dir_i    = dir;
        req_bypass_i = byp;
        req_beats_i  = W'(beats);
        check("idle_ready", req_ready_o, 1);
        @(posedge clk_i); @(negedge clk_i);
        req_valid_i = 1'b0;
        check("cfg_busy", busy_o, 1);
        check("cfg_dir", ring_dir_o, dir);
        check("cfg_bypass", ring_bypass_o, byp);
        check("cfg_en", {tx_en_o, rx_en_o}, 0);
        check("cfg_cnt", {tx_cnt_o, rx_cnt_o}, 0);
        check("cfg_ready", req_ready_o, 0);
        check("cfg_done", done_o, 0);
        drive_hs(p_tx, p_rx, 1'b0);
        mtx = 0; mrx = 0; wd = 0; k = 0;
        fin = (beats == 0);
        to_hit = 1'b0;
        while (!fin && k < 3000) begin
            @(posedge clk_i); @(negedge clk_i);
            k++;
            check("busy_tx_en", tx_en_o, !byp && mtx < beats);
            check("busy_rx_en", rx_en_o, !byp && mrx < beats);
            check("busy_tx_cnt", tx_cnt_o, mtx);
            check("busy_rx_cnt", rx_cnt_o, mrx);
            check("busy_flags", {busy_o, done_o, req_ready_o}, 3'b100);
            check("busy_cfg", {ring_dir_o, ring_bypass_o}, {dir, byp});
            drive_hs(p_tx, p_rx, (k >= 2) && (k <= 1 + stall));
            tx_b = !byp && tx_valid_i && tx_ready_i && mtx < beats;
            rx_b = byp ? (fwd_valid_i && fwd_ready_i && mrx < beats)
                       : (rx_valid_i && rx_ready_i && mrx < beats);
            mtx += int'(tx_b);
            mrx += int'(rx_b);
            if (tx_b || rx_b) wd = 0; else wd++;
            fin = byp ? (mrx == beats) : (mtx == beats && mrx == beats);
            if (!fin && TO_EN && wd == TO) begin
                fin = 1'b1;
                to_hit = 1'b1;
            end
        end
        check("op_bound", fin, 1);
        @(posedge clk_i); @(negedge clk_i);
        check("done_pulse", done_o, 1);
        check("done_timeout", timeout_o, to_hit);
        check("done_flags", {busy_o, req_ready_o, tx_en_o, rx_en_o}, 0);
        check("done_tx_cnt", tx_cnt_o, mtx);
        check("done_rx_cnt", rx_cnt_o, mrx);
        drive_hs(100, 100, 1'b0);
        if (nx_hold) begin
            req_valid_i  = 1'b1;
            req_dir_i    = nx_dir;
            req_bypass_i = nx_byp;
            req_beats_i  = W'(nx_beats);
        end
        @(posedge clk_i); @(negedge clk_i);
        check("idle_flags", {req_ready_o, busy_o, done_o, timeout_o}, 4'b1000);
        check("idle_hold_cnt", {tx_cnt_o, rx_cnt_o}, {W'(mtx), W'(mrx)});
        check("idle_hold_cfg", {ring_dir_o, ring_bypass_o}, {dir, byp});
    endtask

    initial begin
        // Asynchronous reset between clock edges.
        #1 rst_i = 1'b1;
        #2;
        check("rst_flags", {busy_o, done_o, tx_en_o, rx_en_o, timeout_o}, 0);
        check("rst_cnt", {tx_cnt_o, rx_cnt_o}, 0);
        check("rst_cfg", {ring_dir_o, ring_bypass_o}, 2'b01);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check("rst_ready", req_ready_o, 1);

        // Active left, continuous traffic.
        run_op(1'b0, 1'b0, 4, 100, 100, 0, 1'b0, 1'b0, 1'b0, 0);
        // Active right, TX saturates early while RX trickles.
        run_op(1'b1, 1'b0, 3, 100, 35, 0, 1'b0, 1'b0, 1'b0, 0);
        // Bypass with sparse forwarded handshakes, local traffic ignored.
        run_op(1'b0, 1'b1, 5, 80, 60, 0, 1'b0, 1'b0, 1'b0, 0);
        // Single beat.
        run_op(1'b1, 1'b0, 1, 70, 70, 0, 1'b0, 1'b0, 1'b0, 0);
        // Zero beats with the next request held through DONE.
        run_op(1'b1, 1'b0, 0, 100, 100, 0, 1'b1, 1'b0, 1'b0, 2);
        run_op(1'b0, 1'b0, 2, 100, 100, 0, 1'b0, 1'b0, 1'b0, 0);
        // One beat then a long stall: watchdog expiry when enabled, otherwise waits and finishes.
        run_op(1'b0, 1'b0, 2, 100, 100, 20, 1'b0, 1'b0, 1'b0, 0);

        // Reset in the middle of BUSY aborts without a done pulse.
        req_valid_i = 1'b1; req_dir_i = 1'b1; req_bypass_i = 1'b0; req_beats_i = W'(10);
        @(posedge clk_i); @(negedge clk_i);
        req_valid_i = 1'b0;
        drive_hs(100, 100, 1'b0);
        @(posedge clk_i); @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("abort_flags", {busy_o, done_o, tx_en_o, rx_en_o, timeout_o}, 0);
        check("abort_cnt", {tx_cnt_o, rx_cnt_o}, 0);
        check("abort_cfg", {ring_dir_o, ring_bypass_o}, 2'b01);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive_hs(0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); @(negedge clk_i);
            check("abort_idle", {req_ready_o, busy_o, done_o}, 3'b100);
        end

        // Randomized ops.
        for (int i = 0; i < 12; i++) begin
            run_op(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(10)),
                   int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0,
                   1'b0, 1'b0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
